// File: rtl/bell_judge_n.sv
// N-player card-bell arbiter, judge and scorer.
// Round-robin press arbitration, same-colour sum judging, saturating scores and game-end detection.
module bell_judge_n #(
  parameter int NPLAYER   = 4,
  parameter int CW        = 2,
  parameter int NW        = 3,
  parameter int TARGET    = 5,
  parameter int SW        = 10,
  parameter int LOCK      = 8,
  parameter int WIN_SCORE = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPLAYER-1:0]    bell_req,
  input  logic [NPLAYER-1:0]    card_up,
  input  logic [NPLAYER*CW-1:0] card_color,
  input  logic [NPLAYER*NW-1:0] card_num,
  input  logic [7:0]            pile_cnt,
  output logic [NPLAYER*SW-1:0] score,
  output logic                  ring_ack,
  output logic [2:0]            ring_who,
  output logic                  ring_ok,
  output logic                  busy,
  output logic                  game_over,
  output logic [NPLAYER-1:0]    winner
);

  localparam int SUMW = NW + $clog2(NPLAYER);
  localparam int AW   = ((SW > 8) ? SW : 8) + 1;
  localparam int NCOL = 1 << CW;
  localparam int CNTW = (LOCK > 1) ? $clog2(LOCK) : 1;
  localparam logic [SW-1:0] SMAX = {SW{1'b1}};
  localparam logic [SW-1:0] PEN  = SW'(NPLAYER - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_JUDGE   = 3'd1,
    S_UPDATE  = 3'd2,
    S_LOCKOUT = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t                r_state, w_next;
  logic                  r_busy;
  logic [NPLAYER-1:0]    r_prev;
  logic [NPLAYER-1:0]    w_rise;
  logic [2:0]            r_ptr, r_who, r_ring_who, w_pick, w_best;
  logic                  w_any, w_correct, w_end;
  logic [NPLAYER-1:0]    r_up;
  logic [NPLAYER*CW-1:0] r_col;
  logic [NPLAYER*NW-1:0] r_num;
  logic [7:0]            r_pile;
  logic [CNTW-1:0]       r_cnt;
  logic                  r_ok, r_ack, r_over;
  logic [NPLAYER-1:0]    r_winner, w_win;
  logic [SW-1:0]         r_score     [NPLAYER];
  logic [SW-1:0]         w_new_score [NPLAYER];
  logic [AW-1:0]         w_add       [NPLAYER];
  logic [SUMW-1:0]       w_sum       [NCOL];
  logic [SW-1:0]         w_best_val;

  assign w_rise = bell_req & ~r_prev;

  // State register and registered busy flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_any ? S_JUDGE : S_IDLE;
      S_JUDGE:   w_next = S_UPDATE;
      S_UPDATE:  w_next = w_end ? S_OVER : S_LOCKOUT;
      S_LOCKOUT: w_next = (r_cnt == CNTW'(LOCK - 1)) ? S_IDLE : S_LOCKOUT;
      S_OVER:    w_next = S_OVER;
      default:   w_next = S_IDLE;
    endcase
  end

  // Arbitration pick, ring judgement and candidate score update
  always_comb begin
    w_any  = 1'b0;
    w_pick = 3'd0;
    for (int k = 0; k < NPLAYER; k++) begin
      for (int i = 0; i < NPLAYER; i++) begin
        if (!w_any && w_rise[i] && (((int'(r_ptr) + k) % NPLAYER) == i)) begin
          w_any  = 1'b1;
          w_pick = 3'(i);
        end else begin
          w_any  = w_any;
        end
      end
    end

    // Sums are wide enough that no colour total can wrap onto TARGET
    w_correct = 1'b0;
    for (int c = 0; c < NCOL; c++) begin
      w_sum[c] = {SUMW{1'b0}};
      for (int i = 0; i < NPLAYER; i++) begin
        if (r_up[i] && (r_col[i*CW +: CW] == CW'(c))) begin
          w_sum[c] = w_sum[c] + SUMW'(r_num[i*NW +: NW]);
        end else begin
          w_sum[c] = w_sum[c];
        end
      end
      if ((r_up != {NPLAYER{1'b0}}) && (int'(w_sum[c]) == TARGET)) begin
        w_correct = 1'b1;
      end else begin
        w_correct = w_correct;
      end
    end

    for (int i = 0; i < NPLAYER; i++) begin
      w_add[i] = AW'(r_score[i]) + AW'(r_pile);
      if (3'(i) == r_who) begin
        if (r_ok) begin
          w_new_score[i] = (w_add[i] > AW'(SMAX)) ? SMAX : w_add[i][SW-1:0];
        end else begin
          w_new_score[i] = (r_score[i] > PEN) ? (r_score[i] - PEN) : {SW{1'b0}};
        end
      end else begin
        if (r_ok) begin
          w_new_score[i] = r_score[i];
        end else begin
          w_new_score[i] = (r_score[i] == SMAX) ? SMAX : (r_score[i] + SW'(1));
        end
      end
    end

    w_end      = 1'b0;
    w_best     = 3'd0;
    w_best_val = w_new_score[0];
    for (int i = 0; i < NPLAYER; i++) begin
      if (int'(w_new_score[i]) >= WIN_SCORE) begin
        w_end = 1'b1;
      end else begin
        w_end = w_end;
      end
      if (w_new_score[i] > w_best_val) begin
        w_best_val = w_new_score[i];
        w_best     = 3'(i);
      end else begin
        w_best     = w_best;
      end
    end
    w_win = {{(NPLAYER-1){1'b0}}, 1'b1} << w_best;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev     <= bell_req;
      r_ptr      <= 3'd0;
      r_who      <= 3'd0;
      r_up       <= {NPLAYER{1'b0}};
      r_col      <= {(NPLAYER*CW){1'b0}};
      r_num      <= {(NPLAYER*NW){1'b0}};
      r_pile     <= 8'd0;
      r_cnt      <= {CNTW{1'b0}};
      r_ok       <= 1'b0;
      r_ack      <= 1'b0;
      r_ring_who <= 3'd0;
      r_over     <= 1'b0;
      r_winner   <= {NPLAYER{1'b0}};
      for (int i = 0; i < NPLAYER; i++) r_score[i] <= {SW{1'b0}};
    end else begin
      r_prev <= bell_req;
      r_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_who  <= w_pick;
            r_up   <= card_up;
            r_col  <= card_color;
            r_num  <= card_num;
            r_pile <= pile_cnt;
          end
        end
        S_JUDGE: r_ok <= w_correct;
        S_UPDATE: begin
          for (int i = 0; i < NPLAYER; i++) r_score[i] <= w_new_score[i];
          r_ack      <= 1'b1;
          r_ring_who <= r_who;
          r_ptr      <= (r_who == 3'(NPLAYER - 1)) ? 3'd0 : (r_who + 3'd1);
          r_cnt      <= {CNTW{1'b0}};
          if (w_end) begin
            r_over   <= 1'b1;
            r_winner <= w_win;
          end
        end
        S_LOCKOUT: r_cnt <= r_cnt + CNTW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  for (genvar g = 0; g < NPLAYER; g++) begin : g_score
    assign score[g*SW +: SW] = r_score[g];
  end

  assign ring_ack  = r_ack;
  assign ring_who  = r_ring_who;
  assign ring_ok   = r_ok;
  assign busy      = r_busy;
  assign game_over = r_over;
  assign winner    = r_winner;

endmodule
